// File: rtl/adder_pkg.sv
// adder_pkg
//   Definitions shared by the ADDER feed-side logic and the ADDER datapath:
//   kernel-size encodings, the rounds-per-tile mapping, the feed sequencer
//   state type and the interface widths.
package adder_pkg;

    localparam int DATA_W = 73728;  // one multiplier result beat
    localparam int PSUM_W = 864;    // one ADDER partial sum

    localparam logic [3:0] WSIZE_3 = 4'd0;
    localparam logic [3:0] WSIZE_5 = 4'd1;
    localparam logic [3:0] WSIZE_7 = 4'd2;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_FEED,
        FEED_DRAIN
    } feed_state_t;

    // Number of ADDER rounds needed per tile; 0 flags an illegal kernel size.
    function automatic logic [2:0] rounds_of(input logic [3:0] ws);
        case (ws)
            WSIZE_3: rounds_of = 3'd1;
            WSIZE_5: rounds_of = 3'd2;
            WSIZE_7: rounds_of = 3'd4;
            default: rounds_of = 3'd0;
        endcase
    endfunction

    function automatic logic wsize_legal(input logic [3:0] ws);
        wsize_legal = (rounds_of(ws) != 3'd0);
    endfunction

endpackage

// File: rtl/adder_round_cnt.sv
// adder_round_cnt
//   Round-within-tile and tile counters for the ADDER feed sequencer.
//   Ports:
//     clk, rst      clock / synchronous active-high reset
//     clear         restart both counters at a new job
//     active        sequencer is in its feed phase
//     accept        a beat is accepted this cycle
//     rounds        rounds per tile (1, 2 or 4)
//     tiles         tiles in the job (non-zero while active)
//     round_cnt     current round index within the tile
//     last_round    round_cnt is the final round of the tile
//     last_tile     tile_cnt is the final tile of the job
//     gap           active, no beat, and the tile is partly sent
module adder_round_cnt #(
    parameter int TILE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              active,
    input  logic              accept,
    input  logic [2:0]        rounds,
    input  logic [TILE_W-1:0] tiles,
    output logic [1:0]        round_cnt,
    output logic              last_round,
    output logic              last_tile,
    output logic              gap
);

    logic [TILE_W-1:0] tile_cnt;

    assign last_round = ({1'b0, round_cnt} == (rounds - 3'd1));
    assign last_tile  = (tile_cnt == (tiles - TILE_W'(1)));
    // Idle cycles are only harmless on a tile boundary.
    assign gap        = active && !accept && (round_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            round_cnt <= 2'd0;
            tile_cnt  <= '0;
        end else if (accept) begin
            if (last_round) begin
                round_cnt <= 2'd0;
                tile_cnt  <= tile_cnt + TILE_W'(1);
            end else begin
                round_cnt <= round_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/adder_feed_ctrl.sv
// adder_feed_ctrl
//   Transmit-side sequencer for the ADDER input interface. Takes a job of
//   N tiles, pulls multiplier beats over valid/ready, forwards each beat
//   one cycle later stamped with its round index, and counts the returning
//   Psum_valid pulses to signal job completion.
//   Ports:
//     clk, rst                     clock / synchronous active-high reset
//     start, cfg_wsize, cfg_stride, cfg_tiles   job request and config
//     mul_valid, mul_ready, mul_data            upstream beat handshake
//     MUL_results, MUL_DATA_valid, wsize, stride, wround   ADDER input
//     Psum_valid                   ADDER completion pulse, one per tile
//     busy, done, err              status (err is sticky until next start)
module adder_feed_ctrl #(
    parameter int DATA_W = 73728,
    parameter int TILE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        cfg_wsize,
    input  logic              cfg_stride,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic              mul_valid,
    output logic              mul_ready,
    input  logic [DATA_W-1:0] mul_data,
    output logic [DATA_W-1:0] MUL_results,
    output logic              MUL_DATA_valid,
    output logic [3:0]        wsize,
    output logic              stride,
    output logic [2:0]        wround,
    input  logic              Psum_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import adder_pkg::*;

    feed_state_t       state_q, state_d;
    logic [TILE_W-1:0] tiles_q;
    logic [TILE_W-1:0] psum_cnt;
    logic [2:0]        rounds;
    logic [1:0]        round_cnt;
    logic              last_round, last_tile, gap;
    logic              start_ok, start_bad, accept, final_beat;
    logic              psum_full, psum_take, psum_bad, drain_done, done_d;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic [2:0]        wround_p1;

    assign rounds     = rounds_of(wsize);
    assign busy       = (state_q != FEED_IDLE);
    // Ready depends on state alone so upstream never sees a valid->ready loop.
    assign mul_ready  = (state_q == FEED_FEED);
    assign accept     = mul_valid && mul_ready;

    assign start_ok   = (state_q == FEED_IDLE) && start && wsize_legal(cfg_wsize);
    assign start_bad  = (state_q == FEED_IDLE) && start && !wsize_legal(cfg_wsize);
    assign final_beat = accept && last_round && last_tile;

    // Pulses are only meaningful inside a job and only up to the tile count.
    assign psum_full  = (psum_cnt == tiles_q);
    assign psum_take  = Psum_valid && busy && !psum_full;
    assign psum_bad   = Psum_valid && (!busy || psum_full);
    assign drain_done = (state_q == FEED_DRAIN) && psum_full;
    assign done_d     = (start_ok && (cfg_tiles == '0)) || drain_done;

    adder_round_cnt #(.TILE_W(TILE_W)) u_round_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .active     (mul_ready),
        .accept     (accept),
        .rounds     (rounds),
        .tiles      (tiles_q),
        .round_cnt  (round_cnt),
        .last_round (last_round),
        .last_tile  (last_tile),
        .gap        (gap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FEED_IDLE:  if (start_ok && (cfg_tiles != '0)) state_d = FEED_FEED;
            FEED_FEED:  if (final_beat) state_d = FEED_DRAIN;
            FEED_DRAIN: if (psum_full) state_d = FEED_IDLE;
            default:    state_d = FEED_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FEED_IDLE;
            tiles_q  <= '0;
            psum_cnt <= '0;
            wsize    <= 4'd0;
            stride   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            if (start_ok) begin
                wsize    <= cfg_wsize;
                stride   <= cfg_stride;
                tiles_q  <= cfg_tiles;
                psum_cnt <= '0;
                err      <= 1'b0;
            end else if (psum_take) begin
                psum_cnt <= psum_cnt + TILE_W'(1);
            end
            if (start_bad || psum_bad || gap) begin
                err <= 1'b1;
            end
        end
    end

    // Stage p1: accepted beat registered toward ADDER; held when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            wround_p1 <= 3'd0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                data_p1   <= mul_data;
                wround_p1 <= {1'b0, round_cnt};
            end
        end
    end

    assign MUL_results    = data_p1;
    assign MUL_DATA_valid = vld_p1;
    assign wround         = wround_p1;

endmodule

// File: tb/tb_adder_feed_ctrl.sv
module tb_adder_feed_ctrl;

    localparam int DW = 128;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst, start, cfg_stride, mul_valid, mul_ready;
    logic [3:0]    cfg_wsize, wsize;
    logic [TW-1:0] cfg_tiles;
    logic [DW-1:0] mul_data, MUL_results;
    logic          MUL_DATA_valid, stride, Psum_valid, busy, done, err;
    logic [2:0]    wround;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the held ADDER-side outputs.
    logic [DW-1:0] m_data;
    logic [2:0]    m_wr;

    typedef struct {
        logic [3:0]  ws;
        int          n;
        logic        st;
        logic [31:0] gmask;
        int          exp_r;
        bit          legal;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    adder_feed_ctrl #(.DATA_W(DW), .TILE_W(TW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_wsize      (cfg_wsize),
        .cfg_stride     (cfg_stride),
        .cfg_tiles      (cfg_tiles),
        .mul_valid      (mul_valid),
        .mul_ready      (mul_ready),
        .mul_data       (mul_data),
        .MUL_results    (MUL_results),
        .MUL_DATA_valid (MUL_DATA_valid),
        .wsize          (wsize),
        .stride         (stride),
        .wround         (wround),
        .Psum_valid     (Psum_valid),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int rounds_model(input logic [3:0] ws);
        if (ws == 4'd0) return 1;
        if (ws == 4'd1) return 2;
        return 4;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_results"}, MUL_results, '0);
        chk({tag, "_valid"}, MUL_DATA_valid, 0);
        chk({tag, "_wround"}, wround, 0);
        chk({tag, "_wsize"}, wsize, 0);
        chk({tag, "_stride"}, stride, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ready"}, mul_ready, 0);
    endtask

    // One complete job: beats are checked against a queue-free model in
    // which beat k of the job carries round k mod R; done is expected one
    // cycle after the last tile's Psum_valid is taken.
    task automatic run_job(input logic [3:0] ws, input int n, input logic st, input int r,
                           input int vprob, input logic [31:0] gmask, input int pprob);
        int total = n * r;
        int k = 0, psent = 0, c = 0;
        bit exp_err = 0, done_pend = 0, exp_done = 0, acc, sent, fin = 0;
        logic [DW-1:0] d;
        start = 1'b1; cfg_wsize = ws; cfg_tiles = TW'(n); cfg_stride = st;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_wsize", wsize, ws);
        chk("start_stride", stride, st);
        chk("start_err", err, 0);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            chk("ready", mul_ready, (k < total));
            acc = 0;
            sent = 0;
            d = rand_beat();
            mul_data = d;
            if (k < total && !(c < 32 && gmask[c]) && $urandom_range(99) < vprob) begin
                mul_valid = 1'b1;
                acc = 1;
            end else begin
                mul_valid = 1'b0;
                if (k < total && (k % r) != 0) exp_err = 1;
            end
            if (k < total) c++;
            Psum_valid = 1'b0;
            if (psent < k / r && $urandom_range(99) < pprob) begin
                Psum_valid = 1'b1;
                psent++;
                sent = 1;
            end
            step();
            exp_done  = done_pend;
            done_pend = sent && (psent == n);
            if (acc) begin
                k++;
                m_data = d;
                m_wr   = 3'((k - 1) % r);
            end
            chk("beat_valid", MUL_DATA_valid, acc);
            chk("beat_data", MUL_results, m_data);
            chk("beat_wround", wround, m_wr);
            chk("job_err", err, exp_err);
            chk("job_done", done, exp_done);
            chk("stride_stable", stride, st);
            if (exp_done || done) fin = 1;
        end
        mul_valid  = 1'b0;
        Psum_valid = 1'b0;
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL job_timeout: got no done, expected done for ws=%0d n=%0d", ws, n);
        end
        chk("end_busy", busy, 0);
        chk("end_beats", k, total);
        step();
        chk("done_single", done, 0);
        chk("idle_ready", mul_ready, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got running sim, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d0, d1;
        rst = 1'b1; start = 1'b0; cfg_wsize = 4'd0; cfg_stride = 1'b0; cfg_tiles = '0;
        mul_valid = 1'b0; mul_data = '0; Psum_valid = 1'b0;
        m_data = '0; m_wr = 3'd0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        vecs[0] = '{4'd0, 3, 1'b0, 32'h0,  1, 1'b1};
        vecs[1] = '{4'd2, 2, 1'b1, 32'h0,  4, 1'b1};
        vecs[2] = '{4'd1, 2, 1'b0, 32'h2C, 2, 1'b1};
        vecs[3] = '{4'd3, 2, 1'b1, 32'h0,  0, 1'b0};
        vecs[4] = '{4'd0, 0, 1'b0, 32'h0,  1, 1'b1};
        vecs[5] = '{4'd1, 1, 1'b1, 32'h0,  2, 1'b1};

        foreach (vecs[i]) begin
            if (!vecs[i].legal) begin
                start = 1'b1; cfg_wsize = vecs[i].ws; cfg_tiles = TW'(vecs[i].n);
                cfg_stride = vecs[i].st;
                step();
                start = 1'b0;
                chk("illegal_busy", busy, 0);
                chk("illegal_err", err, 1);
                chk("illegal_valid", MUL_DATA_valid, 0);
                step();
                chk("illegal_stay", busy, 0);
            end else if (vecs[i].n == 0) begin
                start = 1'b1; cfg_wsize = vecs[i].ws; cfg_tiles = '0; cfg_stride = vecs[i].st;
                step();
                start = 1'b0;
                chk("zero_done", done, 1);
                chk("zero_busy", busy, 0);
                chk("zero_err", err, 0);
                chk("zero_valid", MUL_DATA_valid, 0);
                step();
                chk("zero_done_once", done, 0);
                chk("zero_valid2", MUL_DATA_valid, 0);
            end else begin
                run_job(vecs[i].ws, vecs[i].n, vecs[i].st, vecs[i].exp_r, 100, vecs[i].gmask, 100);
            end
        end

        // Psum_valid while idle is an error.
        Psum_valid = 1'b1;
        step();
        Psum_valid = 1'b0;
        chk("idle_psum_err", err, 1);
        chk("idle_psum_busy", busy, 0);
        step();

        // Extra Psum_valid while draining a 2-tile job.
        d0 = rand_beat(); d1 = rand_beat();
        start = 1'b1; cfg_wsize = 4'd0; cfg_tiles = TW'(2); cfg_stride = 1'b0;
        step();
        start = 1'b0;
        chk("x_err_cleared", err, 0);
        mul_valid = 1'b1; mul_data = d0;
        step();
        chk("x_beat0", MUL_results, d0);
        mul_data = d1; Psum_valid = 1'b1;
        step();
        chk("x_beat1", MUL_results, d1);
        chk("x_drain_ready", mul_ready, 0);
        mul_valid = 1'b0; Psum_valid = 1'b1;
        step();
        chk("x_no_early_done", done, 0);
        chk("x_busy", busy, 1);
        Psum_valid = 1'b1;
        step();
        Psum_valid = 1'b0;
        chk("x_done", done, 1);
        chk("x_extra_err", err, 1);
        chk("x_idle", busy, 0);
        step();
        chk("x_done_once", done, 0);
        chk("x_err_sticky", err, 1);
        m_data = d1; m_wr = 3'd0;

        // Reset in the middle of tile 1 of a 5x5 job.
        start = 1'b1; cfg_wsize = 4'd1; cfg_tiles = TW'(3); cfg_stride = 1'b1;
        step();
        start = 1'b0;
        mul_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mul_data = rand_beat();
            step();
        end
        chk("mid_wround", wround, 1);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; mul_valid = 1'b0;
        chk_all_zero("midrst");
        m_data = '0; m_wr = 3'd0;
        run_job(4'd0, 2, 1'b0, 1, 100, 32'h0, 100);

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            logic [3:0] ws;
            ws = 4'($urandom_range(2));
            run_job(ws, $urandom_range(1, 4), 1'($urandom_range(1)), rounds_model(ws),
                    $urandom_range(50, 100), 32'h0, 50);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_feed_ctrl.md
Name: adder_feed_ctrl

Overview:
- Transmit-side sequencer for the ADDER input interface (MUL_results / MUL_DATA_valid / wsize / stride / wround).
- Accepts a job of N tiles and pulls multiplier result beats from the upstream MUL array over a valid/ready handshake.
- Drives each tile to ADDER as 1, 2 or 4 contiguous rounds, depending on kernel size, and stamps each round with the correct wround.
- Counts returning Psum_valid pulses and signals done once every tile's partial sum has come back.

Parameters:
- DATA_W, 73728, width of one multiplier result beat (MUL_results).
- TILE_W, 16, width of the tile counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle job request; sampled only in IDLE.
- cfg_wsize  in  4  kernel size: 0=3x3, 1=5x5, 2=7x7; other values are illegal.
- cfg_stride  in  1  stride select, passed through to ADDER.
- cfg_tiles  in  TILE_W  number of tiles in the job.
- mul_valid  in  1  upstream beat valid.
- mul_ready  out  1  beat accepted when mul_valid and mul_ready are both high.
- mul_data  in  DATA_W  upstream beat payload.
- MUL_results  out  DATA_W  registered payload to ADDER.
- MUL_DATA_valid  out  1  ADDER input valid.
- wsize  out  4  latched cfg_wsize.
- stride  out  1  latched cfg_stride.
- wround  out  3  round index within the current tile.
- Psum_valid  in  1  ADDER result pulse, one per completed tile.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse at job completion.
- err  out  1  sticky error flag; cleared by the next accepted start or by rst.

Behaviour:
- Reset: at the first rising edge with rst=1, all outputs go to 0 and the state goes to IDLE. Reset mid-job aborts the job; Psum_valid pulses still outstanding are ignored.
- Rounds per tile, R: wsize 0 -> 1, wsize 1 -> 2, wsize 2 -> 4.
- States: IDLE, FEED, DRAIN.
- IDLE:
  - start with a legal cfg_wsize: latch wsize, stride and cfg_tiles; clear err, tile_cnt, round_cnt and psum_cnt.
  - If cfg_tiles != 0, go to FEED. If cfg_tiles = 0, pulse done on the next cycle and stay in IDLE.
  - start with an illegal cfg_wsize: ignored, err set.
- FEED:
  - mul_ready = 1.
  - Each accepted beat appears one cycle later with MUL_results = mul_data, MUL_DATA_valid = 1 and wround = round_cnt. round_cnt then increments.
  - On round_cnt = R-1, round_cnt wraps to 0 and tile_cnt increments.
  - When the last round of the last tile is accepted, mul_ready drops in the same cycle and the state goes to DRAIN.
  - No accepted beat in a cycle: MUL_DATA_valid = 0 next cycle, wround and MUL_results held.
  - Upstream gaps between tiles are legal. A gap inside a tile (round_cnt != 0) sets err, and the tile resumes when data returns.
- DRAIN: mul_ready = 0. When psum_cnt reaches the latched tile count, pulse done for one cycle and return to IDLE.
- Psum_valid is counted in both FEED and DRAIN. A pulse in IDLE, or one beyond the tile count, sets err and is not counted. A pulse in the same cycle as the final beat is counted.
- start while busy: ignored, no error.
- wsize and stride outputs are stable from start to done.
- mul_ready is combinational from state only; there is no path from mul_valid to mul_ready.

Decomposition:
- Shared package adder_pkg holds:
  - WSIZE_3, WSIZE_5, WSIZE_7 encodings.
  - The rounds_of(wsize) function.
  - The state enum FEED_IDLE, FEED_FEED, FEED_DRAIN.
  - Widths DATA_W and PSUM_W = 864, shared with ADDER.
- One sub-module, adder_round_cnt: round/tile counter with wrap, last-round and last-tile flags, and the mid-tile gap detect.

Test Plan:
- rst, then start with wsize=0, tiles=3, mul_valid held high -> 3 beats with wround=0 each on consecutive cycles, valid 1 cycle after each accept. After 3 Psum_valid pulses, done pulses once and busy drops.
- start with wsize=2, tiles=2, upstream always valid -> wround sequence 0,1,2,3,0,1,2,3 with MUL_DATA_valid high for 8 consecutive cycles, and MUL_results matching each beat.
- wsize=1, tiles=2, mul_valid dropped for 2 cycles after tile 0 completes -> MUL_DATA_valid=0 for 2 cycles, wround held at 1, err stays 0. Then a drop after round 0 of tile 1 -> err=1, and round 1 is still emitted later.
- start with cfg_wsize=3 -> stays IDLE, busy=0, err=1. A later start with wsize=0, tiles=0 -> err cleared, done pulses 1 cycle later, no MUL_DATA_valid.
- Psum_valid pulse in IDLE -> err=1. During DRAIN with tiles=2, a third Psum_valid -> err=1 and done still pulses exactly once.
- rst asserted mid-FEED (tile 1, wround=1) -> next edge: all outputs 0, state IDLE. A new job then runs normally from wround=0.
